// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - reservation-station scheduler feeding the shared ALU
module rs_issue_sched #(
    parameter int RS_SIZE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        disp_en,
    input  logic [10:0] disp_op,
    input  logic [31:0] disp_rs1_val,
    input  logic [4:0]  disp_rs1_rob_id,
    input  logic [31:0] disp_rs2_val,
    input  logic [4:0]  disp_rs2_rob_id,
    input  logic [31:0] disp_imm,
    input  logic [31:0] disp_pc,
    input  logic [3:0]  disp_rob_pos,
    output logic        rs_full,
    input  logic        alu_result,
    input  logic [3:0]  alu_result_rob_pos,
    input  logic [31:0] alu_result_val,
    input  logic        lsb_result,
    input  logic [3:0]  lsb_result_rob_pos,
    input  logic [31:0] lsb_result_val,
    output logic        alu_en,
    output logic [10:0] alu_op,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_pc,
    output logic [3:0]  alu_rob_pos
);
    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] valid;
    logic [RS_SIZE-1:0] pend1;
    logic [RS_SIZE-1:0] pend2;
    logic [3:0]         tag1    [RS_SIZE];
    logic [3:0]         tag2    [RS_SIZE];
    logic [31:0]        val1    [RS_SIZE];
    logic [31:0]        val2    [RS_SIZE];
    logic [10:0]        op      [RS_SIZE];
    logic [31:0]        imm     [RS_SIZE];
    logic [31:0]        pc      [RS_SIZE];
    logic [3:0]         rob_pos [RS_SIZE];

    logic          free_found;
    logic [IW-1:0] free_idx;
    logic          issue_found;
    logic [IW-1:0] issue_idx;

    logic        new_pend1;
    logic        new_pend2;
    logic [31:0] new_val1;
    logic [31:0] new_val2;

    assign rs_full = &valid;

    // Descending scan so the last assignment is the lowest index.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (valid[i] && !pend1[i] && !pend2[i]) begin
                issue_found = 1'b1;
                issue_idx   = IW'(i);
            end
        end
    end

    // Incoming operands may be satisfied by a broadcast on the dispatch edge; ALU wins ties.
    always_comb begin
        new_pend1 = disp_rs1_rob_id[4];
        new_val1  = disp_rs1_val;
        if (disp_rs1_rob_id[4]) begin
            if (alu_result && alu_result_rob_pos == disp_rs1_rob_id[3:0]) begin
                new_pend1 = 1'b0;
                new_val1  = alu_result_val;
            end else if (lsb_result && lsb_result_rob_pos == disp_rs1_rob_id[3:0]) begin
                new_pend1 = 1'b0;
                new_val1  = lsb_result_val;
            end
        end
        new_pend2 = disp_rs2_rob_id[4];
        new_val2  = disp_rs2_val;
        if (disp_rs2_rob_id[4]) begin
            if (alu_result && alu_result_rob_pos == disp_rs2_rob_id[3:0]) begin
                new_pend2 = 1'b0;
                new_val2  = alu_result_val;
            end else if (lsb_result && lsb_result_rob_pos == disp_rs2_rob_id[3:0]) begin
                new_pend2 = 1'b0;
                new_val2  = lsb_result_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid       <= '0;
            alu_en      <= 1'b0;
            alu_op      <= '0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (rollback) begin
            valid  <= '0;
            alu_en <= 1'b0;
        end else if (!rdy) begin
            alu_en <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid[i] && pend1[i]) begin
                    if (alu_result && alu_result_rob_pos == tag1[i]) begin
                        pend1[i] <= 1'b0;
                        val1[i]  <= alu_result_val;
                    end else if (lsb_result && lsb_result_rob_pos == tag1[i]) begin
                        pend1[i] <= 1'b0;
                        val1[i]  <= lsb_result_val;
                    end
                end
                if (valid[i] && pend2[i]) begin
                    if (alu_result && alu_result_rob_pos == tag2[i]) begin
                        pend2[i] <= 1'b0;
                        val2[i]  <= alu_result_val;
                    end else if (lsb_result && lsb_result_rob_pos == tag2[i]) begin
                        pend2[i] <= 1'b0;
                        val2[i]  <= lsb_result_val;
                    end
                end
            end

            // Issue picks a ready (valid) entry, dispatch an invalid one: never the same slot.
            if (issue_found) begin
                alu_en           <= 1'b1;
                alu_op           <= op[issue_idx];
                alu_val1         <= val1[issue_idx];
                alu_val2         <= val2[issue_idx];
                alu_imm          <= imm[issue_idx];
                alu_pc           <= pc[issue_idx];
                alu_rob_pos      <= rob_pos[issue_idx];
                valid[issue_idx] <= 1'b0;
            end else begin
                alu_en <= 1'b0;
            end

            if (disp_en && free_found) begin
                valid[free_idx]   <= 1'b1;
                op[free_idx]      <= disp_op;
                pend1[free_idx]   <= new_pend1;
                pend2[free_idx]   <= new_pend2;
                tag1[free_idx]    <= disp_rs1_rob_id[3:0];
                tag2[free_idx]    <= disp_rs2_rob_id[3:0];
                val1[free_idx]    <= new_val1;
                val2[free_idx]    <= new_val2;
                imm[free_idx]     <= disp_imm;
                pc[free_idx]      <= disp_pc;
                rob_pos[free_idx] <= disp_rob_pos;
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - scoreboard bench for rs_issue_sched
module tb_rs_issue_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        disp_en;
    logic [10:0] disp_op;
    logic [31:0] disp_rs1_val;
    logic [4:0]  disp_rs1_rob_id;
    logic [31:0] disp_rs2_val;
    logic [4:0]  disp_rs2_rob_id;
    logic [31:0] disp_imm;
    logic [31:0] disp_pc;
    logic [3:0]  disp_rob_pos;
    logic        rs_full;
    logic        alu_result;
    logic [3:0]  alu_result_rob_pos;
    logic [31:0] alu_result_val;
    logic        lsb_result;
    logic [3:0]  lsb_result_rob_pos;
    logic [31:0] lsb_result_val;
    logic        alu_en;
    logic [10:0] alu_op;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;

    rs_issue_sched #(.RS_SIZE(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .disp_en(disp_en), .disp_op(disp_op),
        .disp_rs1_val(disp_rs1_val), .disp_rs1_rob_id(disp_rs1_rob_id),
        .disp_rs2_val(disp_rs2_val), .disp_rs2_rob_id(disp_rs2_rob_id),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_pos(disp_rob_pos),
        .rs_full(rs_full),
        .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
        .alu_result_val(alu_result_val),
        .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
        .lsb_result_val(lsb_result_val),
        .alu_en(alu_en), .alu_op(alu_op), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [10:0] op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [10:0] OP_ADDI = {1'b0, 3'b000, 7'b0010011};
    localparam logic [10:0] OP_ADD  = {1'b0, 3'b000, 7'b0110011};
    localparam logic [10:0] OP_SUB  = {1'b1, 3'b000, 7'b0110011};

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every issue must match the oldest expected issue, on its expected edge.
    always @(negedge clk) begin
        if (rst && alu_en) begin
            if (sbq.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_issue: cyc=%0d rob=%0d val1=%h, required no issue", cyc, alu_rob_pos, alu_val1);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checks = checks + 1;
                if (cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL issue_cycle rob=%0d: got edge %0d, required %0d", e.rob, cyc, e.cyc);
                end
                checks = checks + 1;
                if (alu_op !== e.op || alu_val1 !== e.v1 || alu_val2 !== e.v2 ||
                    alu_imm !== e.imm || alu_pc !== e.pc || alu_rob_pos !== e.rob) begin
                    errors = errors + 1;
                    $display("FAIL issue_data: got op=%h v1=%h v2=%h imm=%h pc=%h rob=%0d, required op=%h v1=%h v2=%h imm=%h pc=%h rob=%0d",
                             alu_op, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos,
                             e.op, e.v1, e.v2, e.imm, e.pc, e.rob);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        rollback = 1'b0; disp_en = 1'b0; disp_op = '0;
        disp_rs1_val = '0; disp_rs1_rob_id = '0; disp_rs2_val = '0; disp_rs2_rob_id = '0;
        disp_imm = '0; disp_pc = '0; disp_rob_pos = '0;
        alu_result = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
        lsb_result = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;
    endtask

    task automatic disp(input logic [10:0] op, input logic [31:0] v1, input logic [4:0] id1,
                        input logic [31:0] v2, input logic [4:0] id2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        disp_en = 1'b1; disp_op = op;
        disp_rs1_val = v1; disp_rs1_rob_id = id1;
        disp_rs2_val = v2; disp_rs2_rob_id = id2;
        disp_imm = imm; disp_pc = pc; disp_rob_pos = rob;
    endtask

    task automatic expect_issue(input int c, input logic [10:0] op, input logic [31:0] v1,
                                input logic [31:0] v2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [3:0] rob);
        exp_t e;
        e.cyc = c; e.op = op; e.v1 = v1; e.v2 = v2; e.imm = imm; e.pc = pc; e.rob = rob;
        sbq.push_back(e);
    endtask

    int w;

    initial begin
        idle_inputs();
        rst = 1'b0;
        rdy = 1'b1;
        step(); step();
        chk("reset_alu_en", {31'b0, alu_en}, 32'h0);
        chk("reset_rs_full", {31'b0, rs_full}, 32'h0);
        chk("reset_alu_val1", alu_val1, 32'h0);
        chk("reset_alu_rob_pos", {28'b0, alu_rob_pos}, 32'h0);
        rst = 1'b1;
        step();

        // Ready ADDI: written at edge N, issued at N+1.
        disp(OP_ADDI, 32'd5, 5'h00, 32'd0, 5'h00, 32'd3, 32'h100, 4'd2);
        expect_issue(cyc + 2, OP_ADDI, 32'd5, 32'd0, 32'd3, 32'h100, 4'd2);
        step();
        idle_inputs();
        step(); step(); step();

        // ADD waiting on tag 3, woken by ALU broadcast.
        disp(OP_ADD, 32'd0, 5'h13, 32'd7, 5'h00, 32'd0, 32'h104, 4'd4);
        step();
        idle_inputs();
        step();
        alu_result = 1'b1; alu_result_rob_pos = 4'd3; alu_result_val = 32'hDEADBEEF;
        expect_issue(cyc + 2, OP_ADD, 32'hDEADBEEF, 32'd7, 32'd0, 32'h104, 4'd4);
        step();
        idle_inputs();
        step(); step();

        // LSB broadcast on the dispatch edge satisfies operand 2.
        disp(OP_SUB, 32'd1, 5'h00, 32'd0, 5'h17, 32'd0, 32'h108, 4'd5);
        lsb_result = 1'b1; lsb_result_rob_pos = 4'd7; lsb_result_val = 32'h40;
        expect_issue(cyc + 2, OP_SUB, 32'd1, 32'h40, 32'd0, 32'h108, 4'd5);
        step();
        idle_inputs();
        step(); step();

        // Fill all eight entries pending on tag 15, then wake them together.
        for (int i = 0; i < 8; i++) begin
            disp(OP_ADD, 32'd0, 5'h1F, 32'(i), 5'h00, 32'(i), 32'h200 + 32'(4 * i), 4'(i));
            step();
            if (i == 6) chk("not_full_at_7", {31'b0, rs_full}, 32'h0);
        end
        idle_inputs();
        chk("full_at_8", {31'b0, rs_full}, 32'h1);
        w = cyc + 1;
        for (int i = 0; i < 8; i++)
            expect_issue(w + 1 + i, OP_ADD, 32'h99, 32'(i), 32'(i), 32'h200 + 32'(4 * i), 4'(i));
        alu_result = 1'b1; alu_result_rob_pos = 4'd15; alu_result_val = 32'h99;
        step();
        idle_inputs();
        chk("full_after_wakeup", {31'b0, rs_full}, 32'h1);
        step();
        chk("full_clear_after_issue", {31'b0, rs_full}, 32'h0);
        for (int i = 0; i < 8; i++) step();

        // Rollback discards valid entries, a same-cycle dispatch and a same-cycle wakeup.
        for (int i = 0; i < 4; i++) begin
            disp(OP_ADD, 32'd0, 5'h1E, 32'd0, 5'h00, 32'd0, 32'h300, 4'(8 + i));
            step();
        end
        disp(OP_ADDI, 32'd9, 5'h00, 32'd0, 5'h00, 32'd0, 32'h310, 4'd12);
        alu_result = 1'b1; alu_result_rob_pos = 4'd14; alu_result_val = 32'h77;
        rollback = 1'b1;
        step();
        idle_inputs();
        chk("rollback_rs_full", {31'b0, rs_full}, 32'h0);
        chk("rollback_alu_en", {31'b0, alu_en}, 32'h0);
        alu_result = 1'b1; alu_result_rob_pos = 4'd14; alu_result_val = 32'h77;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) step();

        // Freeze with ready entries; order and values survive.
        for (int i = 0; i < 3; i++) begin
            disp(OP_ADD, 32'd0, 5'h1D, 32'(10 + i), 5'h00, 32'(16 * i), 32'h400 + 32'(4 * i), 4'(1 + i));
            step();
        end
        idle_inputs();
        alu_result = 1'b1; alu_result_rob_pos = 4'd13; alu_result_val = 32'h55;
        w = cyc + 1;
        step();
        idle_inputs();
        rdy = 1'b0;
        disp(OP_ADDI, 32'd1, 5'h00, 32'd2, 5'h00, 32'd0, 32'h500, 4'd9);
        lsb_result = 1'b1; lsb_result_rob_pos = 4'd13; lsb_result_val = 32'h66;
        step(); step(); step();
        chk("frozen_alu_en", {31'b0, alu_en}, 32'h0);
        idle_inputs();
        rdy = 1'b1;
        for (int i = 0; i < 3; i++)
            expect_issue(w + 4 + i, OP_ADD, 32'h55, 32'(10 + i), 32'(16 * i), 32'h400 + 32'(4 * i), 4'(1 + i));
        for (int i = 0; i < 6; i++) step();

        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
